sig_edge_detect: RTL
====================

SIG_EDGE_DETECT -- requirements
Module: sig_edge_detect

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent input channels (e.g. SCL, SDA); legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser flops per channel; legal range 2..4.
REQ-003 Parameter FILTER_LEN, default 3: consecutive-cycle count required to accept a level change; legal range 1..255; used only when the filter is compiled in.
REQ-004 Parameter RESET_LEVEL, default 1'b1: idle level loaded into all level-holding registers at reset.
REQ-005 clk  input  1  sole clock; all registers update on its rising edge.
REQ-006 n_rst  input  1  reset, synchronous and active-low.
REQ-007 sig_in  input  NUM_CH  asynchronous raw inputs, one bit per channel.
REQ-008 ch_en  input  NUM_CH  per-channel edge-reporting enable.
REQ-009 level_out  output  NUM_CH  accepted (synchronised, optionally filtered) level per channel.
REQ-010 rising_edge_found  output  NUM_CH  one-cycle registered pulse per channel on an accepted 0->1 change.
REQ-011 falling_edge_found  output  NUM_CH  one-cycle registered pulse per channel on an accepted 1->0 change.

Function
REQ-012 Each channel SHALL pass sig_in through a SYNC_STAGES-deep flop chain; the last stage is sync_out.
REQ-013 Without the filter, level_out SHALL load sync_out every cycle; an input change stable before edge 1 SHALL appear on level_out after edge SYNC_STAGES+1.
REQ-014 With the filter, a per-channel counter SHALL clear whenever sync_out equals level_out, SHALL increment on each mismatching cycle, and on the FILTER_LEN-th consecutive mismatch SHALL load sync_out into level_out and clear.
REQ-015 With the filter, a stable change SHALL appear on level_out after edge SYNC_STAGES+FILTER_LEN; FILTER_LEN=1 SHALL match the unfiltered latency exactly.
REQ-016 A mismatch lasting fewer than FILTER_LEN cycles SHALL leave level_out unchanged and produce no pulse.
REQ-017 Edge pulses SHALL be registered on the same edge that level_out changes, so each pulse is high for exactly the first cycle level_out holds its new value.
REQ-018 Rising and falling pulses on one channel SHALL be mutually exclusive in any cycle; channels SHALL be fully independent.
REQ-019 While ch_en[i]=0, channel i SHALL keep tracking level_out as normal (counter included) but drive both pulses 0; no pulse SHALL be emitted retroactively when ch_en rises.
REQ-020 The filter counter SHALL be ceil(log2(FILTER_LEN+1)) bits and SHALL never exceed FILTER_LEN-1 (no wrap).

Reset
REQ-021 On a clock edge with n_rst=0: all sync flops and level_out SHALL load RESET_LEVEL, counters SHALL load 0, both pulse outputs SHALL load 0.
REQ-022 Reset asserted mid-filter-count or mid-pulse SHALL abort it; no pulse SHALL be generated by the reset itself or by the first post-reset cycle unless sig_in differs from RESET_LEVEL long enough per REQ-013/015.

Configuration
REQ-023 Macro SIG_EDGE_DETECT_FILTER_EN SHALL compile in the glitch filter (REQ-014..016, REQ-020); when undefined, no counter logic SHALL exist, FILTER_LEN SHALL be ignored, and behaviour SHALL follow REQ-013.

Structure
REQ-024 Package sig_edge_detect_pkg SHALL hold default parameter constants, legal-range limits and the counter-width function.
REQ-025 One sub-module, sig_edge_chan (sync chain, optional filter, pulse registers for one channel), SHALL be instantiated NUM_CH times by a generate loop.
REQ-026 Parameter values outside legal range SHALL trigger an elaboration-time error.

Verification
REQ-027 Reset with sig_in=2'b11 and hold 20 cycles -> level_out=2'b11, no pulses throughout.
REQ-028 No filter, SYNC_STAGES=2: sig_in[0] 1->0 before edge 1 -> falling_edge_found[0] high only in the cycle after edge 3.
REQ-029 Filter on, FILTER_LEN=3: 2-cycle low glitch on sig_in[1] -> no pulse, level_out[1] stays 1; 3-cycle low -> one falling pulse after edge 5, and a later return high gives one rising pulse.
REQ-030 ch_en=2'b01, toggle both inputs -> pulses only on channel 0, level_out tracks both.
REQ-031 Assert n_rst=0 at filter count 2 of 3 -> counter cleared, level_out=RESET_LEVEL, no pulse.
REQ-032 Simultaneous opposite toggles on both channels -> rising on one, falling on the other, same cycle.

Source files
------------

// File: rtl/sig_edge_detect_pkg.sv
// Shared constants for the edge detector: default parameters, legal ranges
// and the glitch-filter counter width helper.
package sig_edge_detect_pkg;

  localparam int DEF_NUM_CH           = 2;
  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_FILTER_LEN       = 3;
  localparam logic DEF_RESET_LEVEL    = 1'b1;

  localparam int MIN_NUM_CH           = 1;
  localparam int MAX_NUM_CH           = 32;
  localparam int MIN_SYNC_STAGES      = 2;
  localparam int MAX_SYNC_STAGES      = 4;
  localparam int MIN_FILTER_LEN       = 1;
  localparam int MAX_FILTER_LEN       = 255;

  // Width able to hold 0..filter_len, i.e. ceil(log2(filter_len+1)), never below 1.
  function automatic int cnt_width(input int filter_len);
    int w;
    w = $clog2(filter_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sig_edge_chan.sv
// One channel: synchroniser chain, optional glitch filter (SIG_EDGE_DETECT_FILTER_EN)
// and registered rising/falling pulse outputs.
module sig_edge_chan
  import sig_edge_detect_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
`ifdef SIG_EDGE_DETECT_FILTER_EN
  parameter int   FILTER_LEN  = DEF_FILTER_LEN,
`endif
  parameter logic RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sig_in,
  input  logic ch_en,
  output logic level_out,
  output logic rising_edge_found,
  output logic falling_edge_found
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   sync_out;
  logic                   accept;

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef SIG_EDGE_DETECT_FILTER_EN
  localparam int             CW       = cnt_width(FILTER_LEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count consecutive mismatches; the FILTER_LEN-th one accepts the new level
  // and restarts the count, so the counter tops out at FILTER_LEN-1.
  always_comb begin
    cnt_d  = '0;
    accept = 1'b0;
    if (sync_out != level_q) begin
      if (cnt_q == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign accept = (sync_out != level_q);
`endif

  // Pulses are decided from the same accept that moves level, so they line up
  // with the first cycle of the new level; ch_en only masks the pulses.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
    level_d = accept ? sync_out : level_q;
    rise_d  = accept & ch_en & sync_out;
    fall_d  = accept & ch_en & ~sync_out;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out          = level_q;
  assign rising_edge_found  = rise_q;
  assign falling_edge_found = fall_q;

endmodule

// File: rtl/sig_edge_detect.sv
// Multi-channel synchronising edge detector; define SIG_EDGE_DETECT_FILTER_EN
// to compile in the per-channel glitch filter.
module sig_edge_detect
  import sig_edge_detect_pkg::*;
#(
  parameter int   NUM_CH      = DEF_NUM_CH,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   FILTER_LEN  = DEF_FILTER_LEN,
  parameter logic RESET_LEVEL = DEF_RESET_LEVEL
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] rising_edge_found,
  output logic [NUM_CH-1:0] falling_edge_found
);

  // FILTER_LEN is range-checked even when the filter is compiled out so a bad
  // value is caught before someone enables the filter.
  if (NUM_CH < MIN_NUM_CH || NUM_CH > MAX_NUM_CH) begin : g_bad_num_ch
    $error("sig_edge_detect: NUM_CH=%0d outside %0d..%0d", NUM_CH, MIN_NUM_CH, MAX_NUM_CH);
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("sig_edge_detect: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, MIN_SYNC_STAGES, MAX_SYNC_STAGES);
  end
  if (FILTER_LEN < MIN_FILTER_LEN || FILTER_LEN > MAX_FILTER_LEN) begin : g_bad_filter
    $error("sig_edge_detect: FILTER_LEN=%0d outside %0d..%0d",
           FILTER_LEN, MIN_FILTER_LEN, MAX_FILTER_LEN);
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sig_edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
`ifdef SIG_EDGE_DETECT_FILTER_EN
      .FILTER_LEN  (FILTER_LEN),
`endif
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk                (clk),
      .n_rst              (n_rst),
      .sig_in             (sig_in[gi]),
      .ch_en              (ch_en[gi]),
      .level_out          (level_out[gi]),
      .rising_edge_found  (rising_edge_found[gi]),
      .falling_edge_found (falling_edge_found[gi])
    );
  end

endmodule
